// File: rtl/key_move_ctrl.sv
// Turns debounced direction-key levels into press / auto-repeat move commands,
// delivered through a single-entry valid/ready output register.
module key_move_ctrl #(
   parameter int unsigned HOLD_DELAY    = 1_000,
   parameter int unsigned REPEAT_PERIOD = 200,
   parameter int unsigned CNT_W         = 21
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [3:0] key_in,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [1:0] cmd_dir,
   output logic       cmd_repeat,
   output logic       cmd_drop
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       held_q, held_d;
   logic [3:0]       key_q;

   logic             valid_q, valid_d;
   logic [1:0]       dir_q, dir_d;
   logic             repeat_q, repeat_d;
   logic             drop_q, drop_d;

   logic [3:0]       rise;
   logic [1:0]       win_dir;
   logic             gen;
   logic             gen_rep;
   logic [1:0]       gen_dir;

   assign rise = key_in & ~key_q;

   // NOTE: every variable gets its default before any branch, so no path can infer a latch.
   always_comb begin
      win_dir = 2'd0;
      if      (rise[0]) win_dir = 2'd0;
      else if (rise[1]) win_dir = 2'd1;
      else if (rise[2]) win_dir = 2'd2;
      else if (rise[3]) win_dir = 2'd3;

      state_d = state_q;
      cnt_d   = cnt_q;
      held_d  = held_q;
      gen     = 1'b0;
      gen_rep = 1'b0;
      gen_dir = win_dir;

      unique case (state_q)
         IDLE: begin
            if (|rise) begin
               gen     = 1'b1;
               held_d  = win_dir;
               cnt_d   = '0;
               state_d = DELAY;
            end
         end
         DELAY: begin
            if (|rise) begin
               gen    = 1'b1;
               held_d = win_dir;
               cnt_d  = '0;
            end else if (!key_in[held_q]) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == HOLD_LAST) begin
               gen     = 1'b1;
               gen_rep = 1'b1;
               gen_dir = held_q;
               cnt_d   = '0;
               state_d = REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REPEAT: begin
            if (|rise) begin
               gen     = 1'b1;
               held_d  = win_dir;
               cnt_d   = '0;
               state_d = DELAY;
            end else if (!key_in[held_q]) begin
               state_d = IDLE;
            end else if (cnt_q == REPEAT_LAST) begin
               gen     = 1'b1;
               gen_rep = 1'b1;
               gen_dir = held_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register: a full, stalled register drops new commands rather than stalling timing.
   always_comb begin
      valid_d  = valid_q;
      dir_d    = dir_q;
      repeat_d = repeat_q;
      drop_d   = 1'b0;
      if (gen && (!valid_q || cmd_ready)) begin
         valid_d  = 1'b1;
         dir_d    = gen_dir;
         repeat_d = gen_rep;
      end else if (gen) begin
         drop_d = 1'b1;
      end else if (valid_q && cmd_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         held_q   <= 2'd0;
         key_q    <= 4'd0;
         valid_q  <= 1'b0;
         dir_q    <= 2'd0;
         repeat_q <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         held_q   <= held_d;
         key_q    <= key_in;
         valid_q  <= valid_d;
         dir_q    <= dir_d;
         repeat_q <= repeat_d;
         drop_q   <= drop_d;
      end
   end

   assign cmd_valid  = valid_q;
   assign cmd_dir    = dir_q;
   assign cmd_repeat = repeat_q;
   assign cmd_drop   = drop_q;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Directed bench for key_move_ctrl: press, auto-repeat, priority/retarget,
// backpressure/drop and reset behaviour, with hand-computed expectations.
module tb_key_move_ctrl;

   localparam int HD = 1000;
   localparam int RP = 200;

   logic       clk = 1'b0;
   logic       nrst;
   logic [3:0] key_in;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic       cmd_repeat;
   logic       cmd_drop;

   int vectors = 0;
   int errors  = 0;

   key_move_ctrl #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .CNT_W(21)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .key_in    (key_in),
      .cmd_ready (cmd_ready),
      .cmd_valid (cmd_valid),
      .cmd_dir   (cmd_dir),
      .cmd_repeat(cmd_repeat),
      .cmd_drop  (cmd_drop)
   );

   always #5 clk = ~clk;

   // Outputs are observed 1 time unit after the edge; inputs change then too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst   = 1'b1;
      key_in = 4'b0000;
      tick();
      tick();
      nrst = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      cmd_ready = 1'b1;
      do_reset();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b0_00_0_0) begin
         errors++;
         $display("FAIL reset_outputs got=%b want=%b", obs, 5'b0_00_0_0);
      end
   endtask

   task automatic test_single_press();
      logic [4:0] obs;
      cmd_ready = 1'b1;
      key_in    = 4'b0001;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_00_0_0) begin
         errors++;
         $display("FAIL press_up got=%b want=%b", obs, 5'b1_00_0_0);
      end
      for (int n = 0; n < 6; n++) begin
         if (n == 2) key_in = 4'b0000;
         tick();
         vectors++;
         if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_up_single cycle=%0d valid=%b want=0", n, cmd_valid);
         end
      end
   endtask

   task automatic test_auto_repeat();
      logic [4:0] obs;
      logic       exp_v;
      do_reset();
      cmd_ready = 1'b1;
      key_in    = 4'b0100;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_10_0_0) begin
         errors++;
         $display("FAIL left_press got=%b want=%b", obs, 5'b1_10_0_0);
      end
      for (int n = 1; n <= HD + 2 * RP + 5; n++) begin
         tick();
         exp_v = (n == HD) || (n == HD + RP) || (n == HD + 2 * RP);
         obs   = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
         vectors++;
         if (exp_v ? (obs !== 5'b1_10_1_0) : (cmd_valid !== 1'b0 || cmd_drop !== 1'b0)) begin
            errors++;
            $display("FAIL left_repeat n=%0d got=%b want_valid=%b dir=10 rep=1", n, obs, exp_v);
         end
      end
      key_in = 4'b0000;
      tick();
      vectors++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL left_release valid=%b want=0", cmd_valid);
      end
   endtask

   task automatic test_priority_retarget();
      logic [4:0] obs;
      logic       exp_v;
      do_reset();
      cmd_ready = 1'b1;
      key_in    = 4'b1001;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_00_0_0) begin
         errors++;
         $display("FAIL prio_up_right got=%b want=%b", obs, 5'b1_00_0_0);
      end
      tick();
      key_in = 4'b0001;
      tick();
      vectors++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL right_release_nocmd valid=%b want=0", cmd_valid);
      end
      key_in = 4'b1001;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_11_0_0) begin
         errors++;
         $display("FAIL right_repress got=%b want=%b", obs, 5'b1_11_0_0);
      end
      // Restarted delay: the first repeat must come HD cycles after the re-press, as right.
      for (int n = 1; n <= HD; n++) begin
         tick();
         exp_v = (n == HD);
         obs   = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
         vectors++;
         if (exp_v ? (obs !== 5'b1_11_1_0) : (cmd_valid !== 1'b0)) begin
            errors++;
            $display("FAIL retarget_delay n=%0d got=%b want_valid=%b dir=11 rep=1", n, obs, exp_v);
         end
      end
      key_in = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      logic [4:0] obs;
      do_reset();
      cmd_ready = 1'b0;
      key_in    = 4'b0010;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_01_0_0) begin
         errors++;
         $display("FAIL bp_first got=%b want=%b", obs, 5'b1_01_0_0);
      end
      key_in = 4'b0000;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_01_0_0) begin
         errors++;
         $display("FAIL bp_hold got=%b want=%b", obs, 5'b1_01_0_0);
      end
      key_in = 4'b0010;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_01_0_1) begin
         errors++;
         $display("FAIL bp_drop got=%b want=%b", obs, 5'b1_01_0_1);
      end
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_01_0_0) begin
         errors++;
         $display("FAIL bp_drop_pulse got=%b want=%b", obs, 5'b1_01_0_0);
      end
      cmd_ready = 1'b1;
      tick();
      vectors++;
      if (cmd_valid !== 1'b0 || cmd_drop !== 1'b0) begin
         errors++;
         $display("FAIL bp_transfer valid=%b drop=%b want 0 0", cmd_valid, cmd_drop);
      end
      key_in = 4'b0000;
      tick();
   endtask

   task automatic test_reset_held_key();
      logic [4:0] obs;
      cmd_ready = 1'b1;
      nrst      = 1'b1;
      key_in    = 4'b0010;
      for (int n = 0; n < 2; n++) begin
         tick();
         vectors++;
         if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_in_reset cycle=%0d valid=%b want=0", n, cmd_valid);
         end
      end
      nrst = 1'b0;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_01_0_0) begin
         errors++;
         $display("FAIL held_after_reset got=%b want=%b", obs, 5'b1_01_0_0);
      end
      key_in = 4'b0000;
      tick();
   endtask

   task automatic test_reset_in_repeat();
      logic [4:0] obs;
      do_reset();
      cmd_ready = 1'b0;
      key_in    = 4'b0001;
      tick();
      for (int n = 1; n <= HD; n++) tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_00_0_1) begin
         errors++;
         $display("FAIL repeat_dropped got=%b want=%b", obs, 5'b1_00_0_1);
      end
      nrst = 1'b1;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b0_00_0_0) begin
         errors++;
         $display("FAIL reset_in_repeat got=%b want=%b", obs, 5'b0_00_0_0);
      end
      key_in    = 4'b0000;
      nrst      = 1'b0;
      cmd_ready = 1'b1;
      for (int n = 0; n < HD + RP + 10; n++) begin
         tick();
         vectors++;
         if (cmd_valid !== 1'b0 || cmd_drop !== 1'b0) begin
            errors++;
            $display("FAIL no_repeat_after_reset n=%0d valid=%b drop=%b want 0 0", n, cmd_valid, cmd_drop);
         end
      end
      key_in = 4'b1000;
      tick();
      obs = {cmd_valid, cmd_dir, cmd_repeat, cmd_drop};
      vectors++;
      if (obs !== 5'b1_11_0_0) begin
         errors++;
         $display("FAIL new_press_after_reset got=%b want=%b", obs, 5'b1_11_0_0);
      end
      key_in = 4'b0000;
      tick();
   endtask

   initial begin
      nrst      = 1'b1;
      key_in    = 4'b0000;
      cmd_ready = 1'b0;
      test_reset();
      test_single_press();
      test_auto_repeat();
      test_priority_retarget();
      test_backpressure();
      test_reset_held_key();
      test_reset_in_repeat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
